ro_trng_core: RTL and testbench

//  Parametrised successor to the fixed ring-oscillator combiner: NUM_RO ring oscillators are

---
 rtl/ro_trng_core_pkg.sv | 24 ++
 rtl/ro_trng_core_if.sv | 32 +++
 rtl/ro.sv | 38 +++
 rtl/ro_health_rct.sv | 56 +++++
 rtl/ro_trng_core.sv | 214 +++++++++++++++++++++
 tb/tb_ro_trng_core.sv | 343 ++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/ro_trng_core_pkg.sv
// ro_trng_core_pkg
//   Shared defaults and types for the ring-oscillator TRNG core.
//   - DEF_* : default parameter values used by the core, its interface and sub-blocks
//   - mode_e: post-processing mode latched when the core is enabled
//   - vn_keep: von Neumann pair filter (a pair is kept only when its two bits differ)
package ro_trng_core_pkg;

    localparam int DEF_NUM_RO     = 16;
    localparam int DEF_NUM_GATES  = 5;
    localparam int DEF_GATE_DELAY = 1;
    localparam int DEF_WORD_W     = 8;
    localparam int DEF_RCT_CUTOFF = 32;

    typedef enum logic {
        MODE_RAW = 1'b0,
        MODE_VN  = 1'b1
    } mode_e;

    // A von Neumann pair produces an output bit only for 01 or 10.
    function automatic logic vn_keep(input logic a, input logic b);
        return a ^ b;
    endfunction

endpackage

// File: rtl/ro_trng_core_if.sv
// ro_trng_core_if
//   Output side of the TRNG core: packed word with valid/ready handshake plus
//   the two sticky status flags.
//   master: core side (drives data_out, data_valid, health_fail, overflow)
//   slave : consumer side (drives data_ready)
interface ro_trng_core_if
    import ro_trng_core_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
);
    logic [WORD_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;
    logic              health_fail;
    logic              overflow;

    modport master (
        output data_out,
        output data_valid,
        output health_fail,
        output overflow,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        input  health_fail,
        input  overflow,
        output data_ready
    );
endinterface

// File: rtl/ro.sv
// ro
//   Clocked behavioural model of one ring-oscillator cell. The silicon cell is a
//   free-running loop of NUM_GATES inverters; here a phase accumulator whose step
//   shrinks with the loop delay gives each lane its own frequency and start phase.
//   clock, reset_n : model clock and asynchronous active-low reset
//   enable         : 1 runs the oscillator, 0 holds its phase
//   osc            : oscillator output (asynchronous to any consumer)
module ro
    import ro_trng_core_pkg::*;
#(
    parameter int NUM_GATES  = DEF_NUM_GATES,
    parameter int GATE_DELAY = DEF_GATE_DELAY,
    parameter int SEED       = 0
) (
    input  logic clock,
    input  logic reset_n,
    input  logic enable,
    output logic osc
);
    localparam int              LOOP_DELAY = NUM_GATES * GATE_DELAY;
    localparam logic [7:0]      STEP       = 8'(((2 * SEED + 1) * 37) / LOOP_DELAY + 1);
    localparam logic [7:0]      PHASE0     = 8'(SEED * 16);

    logic [7:0] phase_r;

    // Phase accumulator; the MSB is the oscillator output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase_r <= PHASE0;
        end else if (enable) begin
            phase_r <= phase_r + STEP;
        end else begin
            phase_r <= phase_r;
        end
    end

    assign osc = phase_r[7];
endmodule

// File: rtl/ro_health_rct.sv
// ro_health_rct
//   Repetition-count health test on the raw bit stream. Counts identical
//   consecutive bits (restarting at 1 on a change, saturating at CUTOFF); once the
//   count has reached CUTOFF, fail sets on the following edge and stays set until reset.
//   clock, reset_n : clock and asynchronous active-low reset
//   bit_in/valid_in: raw bit stream
//   fail           : sticky failure flag (registered)
module ro_health_rct
    import ro_trng_core_pkg::*;
#(
    parameter int CUTOFF = DEF_RCT_CUTOFF
) (
    input  logic clock,
    input  logic reset_n,
    input  logic bit_in,
    input  logic valid_in,
    output logic fail
);
    localparam int            CW  = $clog2(CUTOFF + 1);
    localparam logic [CW-1:0] CUT = CW'(CUTOFF);

    logic [CW-1:0] count_r;
    logic          last_r;
    logic          fail_r;

    // Run-length counter; a zero count means no bit has been seen since reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= '0;
            last_r  <= 1'b0;
        end else if (valid_in) begin
            last_r <= bit_in;
            if ((count_r == '0) || (bit_in != last_r)) begin
                count_r <= CW'(1);
            end else if (count_r != CUT) begin
                count_r <= count_r + CW'(1);
            end else begin
                count_r <= count_r;
            end
        end else begin
            count_r <= count_r;
            last_r  <= last_r;
        end
    end

    // Sticky failure flag, set one edge after the run length reaches the cutoff.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fail_r <= 1'b0;
        end else begin
            fail_r <= fail_r | (count_r == CUT);
        end
    end

    assign fail = fail_r;
endmodule

// File: rtl/ro_trng_core.sv
// ro_trng_core
//   NUM_RO ring oscillators -> 2-flop synchronisers -> stage0 register -> LOG_RO
//   registered XOR levels -> optional von Neumann debias -> WORD_W packer with a
//   one-word holding register. A repetition-count test watches the raw bits.
//   clock, reset_n : single clock, asynchronous active-low reset
//   enable         : runs ROs and sampling; 0 discards partial word and pair state
//   debias         : 1 = von Neumann mode, captured on the enable rising edge
//   test_mode      : 1 = test_bits replace the synchronised RO samples
//   test_bits      : deterministic per-lane source
//   bus            : data_out/data_valid/data_ready/health_fail/overflow
module ro_trng_core
    import ro_trng_core_pkg::*;
#(
    parameter int NUM_RO     = DEF_NUM_RO,
    parameter int NUM_GATES  = DEF_NUM_GATES,
    parameter int GATE_DELAY = DEF_GATE_DELAY,
    parameter int WORD_W     = DEF_WORD_W,
    parameter int RCT_CUTOFF = DEF_RCT_CUTOFF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              debias,
    input  logic              test_mode,
    input  logic [NUM_RO-1:0] test_bits,
    ro_trng_core_if.master    bus
);
    localparam int                LOG_RO   = $clog2(NUM_RO);
    localparam int                CNT_W    = $clog2(WORD_W);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(WORD_W - 1);

    // One XOR level: pairs of lanes fold into the lower half, upper half reads zero.
    function automatic logic [NUM_RO-1:0] fold(input logic [NUM_RO-1:0] v);
        fold = '0;
        for (int i = 0; i < NUM_RO / 2; i++) begin
            fold[i] = v[2*i] ^ v[2*i+1];
        end
    endfunction

    logic [NUM_RO-1:0] ro_out_s;
    logic [NUM_RO-1:0] sync1_r;
    logic [NUM_RO-1:0] sync2_r;
    logic [NUM_RO-1:0] lvl_r [LOG_RO+1];
    logic [LOG_RO:0]   lvl_v_r;
    logic              raw_bit_s;
    logic              raw_valid_s;
    logic              en_q_r;
    mode_e             mode_r;
    logic              pair_have_r;
    logic              pair_a_r;
    logic              vn_valid_r;
    logic              vn_bit_r;
    logic              pk_valid_s;
    logic              pk_bit_s;
    logic              fail_s;
    logic              drain_s;
    logic [WORD_W-1:0] sh_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [WORD_W-1:0] hold_r;
    logic              hold_v_r;
    logic              ovf_r;

    for (genvar g = 0; g < NUM_RO; g++) begin : g_ro
        ro #(
            .NUM_GATES  (NUM_GATES),
            .GATE_DELAY (GATE_DELAY),
            .SEED       (g)
        ) u_ro (
            .clock   (clock),
            .reset_n (reset_n),
            .enable  (enable),
            .osc     (ro_out_s[g])
        );
    end

    // Two-flop synchroniser for the asynchronous RO outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_r <= '0;
            sync2_r <= '0;
        end else begin
            sync1_r <= ro_out_s;
            sync2_r <= sync1_r;
        end
    end

    // Stage0 capture and XOR tree. Valid is gated by enable at every level so a
    // pause empties the tree and no pre-pause sample reaches the new mode.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int l = 0; l <= LOG_RO; l++) begin
                lvl_r[l] <= '0;
            end
            lvl_v_r <= '0;
        end else begin
            lvl_r[0]   <= test_mode ? test_bits : sync2_r;
            lvl_v_r[0] <= enable;
            for (int l = 1; l <= LOG_RO; l++) begin
                lvl_r[l]   <= fold(lvl_r[l-1]);
                lvl_v_r[l] <= lvl_v_r[l-1] & enable;
            end
        end
    end

    // Only bit 0 of the last level is non-zero, so the reduction equals that bit.
    assign raw_bit_s   = ^lvl_r[LOG_RO];
    assign raw_valid_s = lvl_v_r[LOG_RO];

    // Mode is latched only on the enable rising edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            en_q_r <= 1'b0;
            mode_r <= MODE_RAW;
        end else begin
            en_q_r <= enable;
            if (enable && !en_q_r) begin
                mode_r <= mode_e'(debias);
            end else begin
                mode_r <= mode_r;
            end
        end
    end

    // Von Neumann pairing: first bit of a pair is held in pair_a_r; the emitted
    // bit equals the first bit (10 -> 1, 01 -> 0) and appears one cycle after b.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pair_have_r <= 1'b0;
            pair_a_r    <= 1'b0;
            vn_valid_r  <= 1'b0;
            vn_bit_r    <= 1'b0;
        end else if (!enable || (mode_r != MODE_VN)) begin
            pair_have_r <= 1'b0;
            pair_a_r    <= 1'b0;
            vn_valid_r  <= 1'b0;
            vn_bit_r    <= 1'b0;
        end else begin
            vn_valid_r <= 1'b0;
            if (raw_valid_s) begin
                if (!pair_have_r) begin
                    pair_have_r <= 1'b1;
                    pair_a_r    <= raw_bit_s;
                end else begin
                    pair_have_r <= 1'b0;
                    vn_valid_r  <= vn_keep(pair_a_r, raw_bit_s);
                    vn_bit_r    <= pair_a_r;
                end
            end
        end
    end

    // Packer input select.
    always_comb begin
        pk_valid_s = 1'b0;
        pk_bit_s   = 1'b0;
        if (mode_r == MODE_VN) begin
            pk_valid_s = vn_valid_r;
            pk_bit_s   = vn_bit_r;
        end else begin
            pk_valid_s = raw_valid_s;
            pk_bit_s   = raw_bit_s;
        end
    end

    ro_health_rct #(
        .CUTOFF (RCT_CUTOFF)
    ) u_rct (
        .clock    (clock),
        .reset_n  (reset_n),
        .bit_in   (raw_bit_s),
        .valid_in (raw_valid_s),
        .fail     (fail_s)
    );

    assign drain_s = hold_v_r & bus.data_ready;

    // Packer and holding register. New bits shift in at the MSB so the oldest bit
    // ends at the LSB; a completed word either moves to holding or is dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sh_r     <= '0;
            cnt_r    <= '0;
            hold_r   <= '0;
            hold_v_r <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            if (drain_s) begin
                hold_v_r <= 1'b0;
            end
            if (!enable || fail_s) begin
                sh_r  <= '0;
                cnt_r <= '0;
            end else if (pk_valid_s) begin
                if (cnt_r == LAST_IDX) begin
                    cnt_r <= '0;
                    if (!hold_v_r || drain_s) begin
                        hold_r   <= {pk_bit_s, sh_r[WORD_W-1:1]};
                        hold_v_r <= 1'b1;
                    end else begin
                        ovf_r <= 1'b1;
                    end
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    sh_r  <= {pk_bit_s, sh_r[WORD_W-1:1]};
                end
            end
        end
    end

    assign bus.data_out    = hold_r;
    assign bus.data_valid  = hold_v_r;
    assign bus.health_fail = fail_s;
    assign bus.overflow    = ovf_r;
endmodule

// File: tb/tb_ro_trng_core.sv
// tb_ro_trng_core
//   Directed bench for ro_trng_core (NUM_RO=16, WORD_W=8, RCT_CUTOFF=32, test_mode=1).
//   Edge E0 is the first rising edge with enable=1; a raw bit captured at Ek is
//   consumed by the packer at E(k+5) in raw mode and its pair output at E(k+6)
//   in debias mode (pair output register adds one more edge before the packer).
module tb_ro_trng_core;

    logic        clock     = 1'b0;
    logic        reset_n   = 1'b0;
    logic        enable    = 1'b0;
    logic        debias    = 1'b0;
    logic        test_mode = 1'b1;
    logic [15:0] test_bits = 16'h0000;

    int vectors     = 0;
    int miscompares = 0;

    ro_trng_core_if #(.WORD_W(8)) bus ();

    ro_trng_core #(
        .NUM_RO     (16),
        .NUM_GATES  (5),
        .GATE_DELAY (1),
        .WORD_W     (8),
        .RCT_CUTOFF (32)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .debias    (debias),
        .test_mode (test_mode),
        .test_bits (test_bits),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        enable         = 1'b0;
        debias         = 1'b0;
        test_mode      = 1'b1;
        test_bits      = 16'h0000;
        bus.data_ready = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (bus.data_out !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_data_out: got %h want 00", bus.data_out);
        end
        vectors++;
        if (bus.data_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_data_valid: got %b want 0", bus.data_valid);
        end
        vectors++;
        if (bus.health_fail !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_health_fail: got %b want 0", bus.health_fail);
        end
        vectors++;
        if (bus.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_overflow: got %b want 0", bus.overflow);
        end
    endtask

    // Raw bits 1,0,1,... -> 8'h55 in holding after E12.
    task automatic test_raw();
        do_reset();
        enable = 1'b1;
        for (int n = 0; n <= 12; n++) begin
            test_bits = (n % 2 == 0) ? 16'h0001 : 16'h0000;
            tick();
            if (n == 11) begin
                vectors++;
                if (bus.data_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL raw_valid_early: got %b want 0", bus.data_valid);
                end
            end
            if (n == 12) begin
                vectors++;
                if (bus.data_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL raw_valid: got %b want 1", bus.data_valid);
                end
                vectors++;
                if (bus.data_out !== 8'h55) begin
                    miscompares++;
                    $display("FAIL raw_data: got %h want 55", bus.data_out);
                end
                vectors++;
                if (bus.health_fail !== 1'b0) begin
                    miscompares++;
                    $display("FAIL raw_health: got %b want 0", bus.health_fail);
                end
            end
        end
    endtask

    // Same stimulus in debias mode: pairs 10 -> eight 1s, word ready after E21.
    task automatic test_debias();
        do_reset();
        debias = 1'b1;
        enable = 1'b1;
        for (int n = 0; n <= 21; n++) begin
            test_bits = (n % 2 == 0) ? 16'h0001 : 16'h0000;
            tick();
            if (n == 20) begin
                vectors++;
                if (bus.data_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL vn_valid_early: got %b want 0", bus.data_valid);
                end
            end
            if (n == 21) begin
                vectors++;
                if (bus.data_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL vn_valid: got %b want 1", bus.data_valid);
                end
                vectors++;
                if (bus.data_out !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL vn_data: got %h want ff", bus.data_out);
                end
            end
        end
    endtask

    // Constant raw 0s: 32nd bit counted at E36, health_fail at E37, no words after.
    task automatic test_rct();
        do_reset();
        enable         = 1'b1;
        bus.data_ready = 1'b1;
        test_bits      = 16'h0003;
        for (int n = 0; n <= 44; n++) begin
            tick();
            if (n == 12) begin
                vectors++;
                if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h00) begin
                    miscompares++;
                    $display("FAIL rct_first_word: got valid=%b data=%h want valid=1 data=00",
                             bus.data_valid, bus.data_out);
                end
            end
            if (n == 36) begin
                vectors++;
                if (bus.health_fail !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rct_fail_early: got %b want 0", bus.health_fail);
                end
            end
            if (n == 37) begin
                vectors++;
                if (bus.health_fail !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rct_fail: got %b want 1", bus.health_fail);
                end
            end
            if (n >= 37) begin
                vectors++;
                if (bus.data_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rct_no_valid n=%0d: got %b want 0", n, bus.data_valid);
                end
            end
        end
    endtask

    // Backpressure: second word dropped at E20, one-cycle ready drains the first.
    task automatic test_overflow();
        do_reset();
        enable = 1'b1;
        for (int n = 0; n <= 28; n++) begin
            test_bits      = (n % 2 == 0) ? 16'h0001 : 16'h0000;
            bus.data_ready = (n == 21) ? 1'b1 : 1'b0;
            tick();
            if (n == 19) begin
                vectors++;
                if (bus.overflow !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ovf_early: got %b want 0", bus.overflow);
                end
            end
            if (n == 20) begin
                vectors++;
                if (bus.overflow !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ovf_set: got %b want 1", bus.overflow);
                end
                vectors++;
                if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h55) begin
                    miscompares++;
                    $display("FAIL ovf_hold: got valid=%b data=%h want valid=1 data=55",
                             bus.data_valid, bus.data_out);
                end
            end
            if (n == 21 || n == 27) begin
                vectors++;
                if (bus.data_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL ovf_drained n=%0d: got %b want 0", n, bus.data_valid);
                end
            end
            if (n == 28) begin
                vectors++;
                if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h55) begin
                    miscompares++;
                    $display("FAIL ovf_third_word: got valid=%b data=%h want valid=1 data=55",
                             bus.data_valid, bus.data_out);
                end
                vectors++;
                if (bus.overflow !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ovf_sticky: got %b want 1", bus.overflow);
                end
            end
        end
    endtask

    // Asynchronous reset with bit counter at 5, then a fresh 1,1,0,0 pattern -> 8'h33.
    task automatic test_reset_midword();
        do_reset();
        enable = 1'b1;
        for (int n = 0; n <= 17; n++) begin
            test_bits = (n % 2 == 0) ? 16'h0001 : 16'h0000;
            tick();
        end
        vectors++;
        if (bus.data_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre_valid: got %b want 1", bus.data_valid);
        end
        #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.data_out !== 8'h00 || bus.data_valid !== 1'b0 ||
            bus.health_fail !== 1'b0 || bus.overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_async_reset: got data=%h valid=%b hf=%b ovf=%b want 00 0 0 0",
                     bus.data_out, bus.data_valid, bus.health_fail, bus.overflow);
        end
        test_bits = 16'h0000;
        tick();
        tick();
        reset_n = 1'b1;
        for (int n = 0; n <= 12; n++) begin
            test_bits = (n % 4 < 2) ? 16'h0001 : 16'h0000;
            tick();
            if (n == 11) begin
                vectors++;
                if (bus.data_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL mid_fresh_early: got %b want 0", bus.data_valid);
                end
            end
            if (n == 12) begin
                vectors++;
                if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h33) begin
                    miscompares++;
                    $display("FAIL mid_fresh_word: got valid=%b data=%h want valid=1 data=33",
                             bus.data_valid, bus.data_out);
                end
            end
        end
    endtask

    // Pause enable for 3 cycles with 3 bits packed, resume in debias mode.
    task automatic test_enable_pause();
        do_reset();
        enable = 1'b1;
        for (int n = 0; n <= 15; n++) begin
            test_bits = (n % 2 == 0) ? 16'h0001 : 16'h0000;
            tick();
        end
        enable = 1'b0;
        for (int n = 16; n <= 18; n++) begin
            test_bits = (n % 2 == 0) ? 16'h0001 : 16'h0000;
            tick();
        end
        vectors++;
        if (bus.data_valid !== 1'b1 || bus.data_out !== 8'h55) begin
            miscompares++;
            $display("FAIL pause_hold_kept: got valid=%b data=%h want valid=1 data=55",
                     bus.data_valid, bus.data_out);
        end
        enable         = 1'b1;
        debias         = 1'b1;
        bus.data_ready = 1'b1;
        for (int m = 0; m <= 21; m++) begin
            test_bits = (m % 2 == 0) ? 16'h0001 : 16'h0000;
            tick();
            bus.data_ready = 1'b0;
            if (m == 0 || m == 20) begin
                vectors++;
                if (bus.data_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL pause_valid m=%0d: got %b want 0", m, bus.data_valid);
                end
            end
            if (m == 21) begin
                vectors++;
                if (bus.data_valid !== 1'b1 || bus.data_out !== 8'hFF) begin
                    miscompares++;
                    $display("FAIL pause_new_mode: got valid=%b data=%h want valid=1 data=ff",
                             bus.data_valid, bus.data_out);
                end
                vectors++;
                if (bus.overflow !== 1'b0) begin
                    miscompares++;
                    $display("FAIL pause_overflow: got %b want 0", bus.overflow);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_debias();
        test_rct();
        test_overflow();
        test_reset_midword();
        test_enable_pause();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
